skein_nonce_scheduler: RTL and testbench

- Sequencer that drives one skein_top core through a nonce sweep without CPU involvement per hash.
- Holds a programmed message of MSG_WORDS 64-bit words and patches the current nonce into one word.
- For each nonce it resets the core, feeds the message over the core's src interface, collects HS/64 digest words from the dst interface, and compares the final digest word against a 64-bit target.
- Sits between the bus-slave register wrapper and skein_top.

---
 rtl/skein_nonce_scheduler.sv | 253 +++++++++++++++++++++++++
 tb/tb_skein_nonce_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skein_nonce_scheduler.sv
// Nonce-sweep sequencer for one skein core: per nonce it resets the core, feeds the message, drains the digest and compares it.
// Latency per nonce: 2 reset cycles + MSG_WORDS src handshakes + core latency + OUT_WORDS dst writes + 1 compare cycle.
// Backpressure: din is held until the core pulses src_read; the digest sink never stalls (dst_ready tied low).
module skein_nonce_scheduler #(
    parameter int HS        = 512,
    parameter int MSG_WORDS = 10,
    parameter int NONCE_IDX = 9,
    parameter int TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [63:0] cfg_wdata,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
    input  logic [63:0] target,
    output logic        core_rst,
    output logic        src_ready,
    input  logic        src_read,
    output logic [63:0] din,
    output logic        dst_ready,
    input  logic        dst_write,
    input  logic [63:0] dout,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic [31:0] cur_nonce,
    output logic        error
);

    localparam int OUT_WORDS = HS / 64;
    localparam int TW        = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_FEED,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          core_rst_q, core_rst_d;
    logic          src_ready_q, src_ready_d;
    logic [63:0]   din_q, din_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          found_q, found_d;
    logic [31:0]   found_nonce_q, found_nonce_d;
    logic [31:0]   cur_nonce_q, cur_nonce_d;
    logic          error_q, error_d;
    logic [31:0]   nonce_end_q, nonce_end_d;
    logic [63:0]   target_q, target_d;
    logic [3:0]    idx_q, idx_d;
    logic          crst_cnt_q, crst_cnt_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [63:0]   last_word_q, last_word_d;

    logic [63:0]   msg_mem [16];
    logic [3:0]    word_sel;
    logic [63:0]   word_val;

    // Message store; writes are locked out during a sweep so din never changes under the core.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy_q) begin
            msg_mem[cfg_addr] <= cfg_wdata;
        end
    end

    // Next word to present on din, with the current nonce patched into its low half.
    always_comb begin
        word_sel = (state_q == S_FEED) ? (idx_q + 4'd1) : 4'd0;
        word_val = msg_mem[word_sel];
        if (word_sel == 4'(NONCE_IDX)) begin
            word_val[31:0] = cur_nonce_q;
        end
    end

    // Sweep sequencing; abort in any active state overrides whatever else happened this cycle.
    always_comb begin
        state_d       = state_q;
        core_rst_d    = core_rst_q;
        src_ready_d   = src_ready_q;
        din_d         = din_q;
        busy_d        = busy_q;
        done_d        = done_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        cur_nonce_d   = cur_nonce_q;
        error_d       = error_q;
        nonce_end_d   = nonce_end_q;
        target_d      = target_q;
        idx_d         = idx_q;
        crst_cnt_d    = crst_cnt_q;
        wcnt_d        = wcnt_q;
        tmo_d         = tmo_q;
        last_word_d   = last_word_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_CRST;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    found_d     = 1'b0;
                    error_d     = 1'b0;
                    cur_nonce_d = nonce_start;
                    nonce_end_d = nonce_end;
                    target_d    = target;
                    crst_cnt_d  = 1'b0;
                    core_rst_d  = 1'b1;
                    src_ready_d = 1'b1;
                end
            end
            S_CRST: begin
                if (!crst_cnt_q) begin
                    crst_cnt_d = 1'b1;
                end else begin
                    state_d     = S_FEED;
                    core_rst_d  = 1'b0;
                    src_ready_d = 1'b0;
                    idx_d       = 4'd0;
                    din_d       = word_val;
                end
            end
            S_FEED: begin
                if (src_read) begin
                    if (idx_q == 4'(MSG_WORDS - 1)) begin
                        state_d     = S_DRAIN;
                        src_ready_d = 1'b1;
                        wcnt_d      = 4'd0;
                        tmo_d       = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        din_d = word_val;
                    end
                end
            end
            S_DRAIN: begin
                if (dst_write) begin
                    tmo_d  = '0;
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'(OUT_WORDS - 1)) begin
                        last_word_d = dout;
                        state_d     = S_CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    core_rst_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (last_word_q <= target_q) begin
                    found_d       = 1'b1;
                    found_nonce_d = cur_nonce_q;
                    state_d       = S_DONE;
                end else if (cur_nonce_q == nonce_end_q) begin
                    state_d = S_DONE;
                end else begin
                    cur_nonce_d = cur_nonce_q + 32'd1;
                    crst_cnt_d  = 1'b0;
                    core_rst_d  = 1'b1;
                    state_d     = S_CRST;
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                core_rst_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            core_rst_d    = 1'b1;
            src_ready_d   = 1'b1;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            found_d       = found_q;
            found_nonce_d = found_nonce_q;
            cur_nonce_d   = cur_nonce_q;
            error_d       = error_q;
        end
    end

    // State and registered outputs; reset parks the core in reset with no result reported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            core_rst_q    <= 1'b1;
            src_ready_q   <= 1'b1;
            din_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            cur_nonce_q   <= '0;
            error_q       <= 1'b0;
            nonce_end_q   <= '0;
            target_q      <= '0;
            idx_q         <= '0;
            crst_cnt_q    <= 1'b0;
            wcnt_q        <= '0;
            tmo_q         <= '0;
            last_word_q   <= '0;
        end else begin
            state_q       <= state_d;
            core_rst_q    <= core_rst_d;
            src_ready_q   <= src_ready_d;
            din_q         <= din_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            cur_nonce_q   <= cur_nonce_d;
            error_q       <= error_d;
            nonce_end_q   <= nonce_end_d;
            target_q      <= target_d;
            idx_q         <= idx_d;
            crst_cnt_q    <= crst_cnt_d;
            wcnt_q        <= wcnt_d;
            tmo_q         <= tmo_d;
            last_word_q   <= last_word_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign src_ready   = src_ready_q;
    assign din         = din_q;
    assign dst_ready   = 1'b0;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign cur_nonce   = cur_nonce_q;
    assign error       = error_q;

endmodule

// File: tb/tb_skein_nonce_scheduler.sv
// Bench for skein_nonce_scheduler: behavioural skein core stand-in plus sweep reference model and scoreboard.
// Latency: not applicable (testbench).
// Backpressure: the core stand-in stalls src_read and spaces dst_write randomly.
module tb_skein_nonce_scheduler;

    localparam int HS        = 512;
    localparam int MSG_WORDS = 10;
    localparam int NONCE_IDX = 9;
    localparam int TIMEOUT   = 16;
    localparam int OUT_WORDS = HS / 64;

    logic        clk;
    logic        reset_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [63:0] cfg_wdata;
    logic        start;
    logic        abort;
    logic [31:0] nonce_start;
    logic [31:0] nonce_end;
    logic [63:0] target;
    logic        core_rst;
    logic        src_ready;
    logic        src_read;
    logic [63:0] din;
    logic        dst_ready;
    logic        dst_write;
    logic [63:0] dout;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] found_nonce;
    logic [31:0] cur_nonce;
    logic        error;

    skein_nonce_scheduler #(
        .HS(HS), .MSG_WORDS(MSG_WORDS), .NONCE_IDX(NONCE_IDX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .abort(abort), .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .core_rst(core_rst), .src_ready(src_ready), .src_read(src_read), .din(din),
        .dst_ready(dst_ready), .dst_write(dst_write), .dout(dout),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
        .cur_nonce(cur_nonce), .error(error)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int crst_falls = 0;
    int srdy_rise_cyc = 0;
    int err_rise_cyc = 0;
    int mode = 0;
    int max_reads = 99;

    logic [63:0] msg_m [16];
    logic [31:0] fn_model = 32'd0;
    logic [63:0] exp_din_q [$];

    typedef struct packed {
        logic        fnd;
        logic [31:0] fn;
        logic [31:0] cur;
        logic        err;
    } res_t;
    res_t exp_res_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Last digest word the stand-in core produces for a given nonce.
    function automatic logic [63:0] lw_func(input int m, input logic [31:0] n);
        case (m)
            0:       return 64'h8000_0000_0000_0001;
            1:       return (n == 32'd2) ? 64'h10 : {32'h1, n};
            default: return {n ^ 32'h5A5A_5A5A, n * 32'h9E37_79B9};
        endcase
    endfunction

    function automatic void push_words(input logic [31:0] n, input int cnt);
        logic [63:0] w;
        for (int k = 0; k < cnt; k++) begin
            w = msg_m[k];
            if (k == NONCE_IDX) w[31:0] = n;
            exp_din_q.push_back(w);
        end
    endfunction

    // Reference sweep: hash nonces in order, stop on first hit or after the end nonce.
    function automatic int predict(input logic [31:0] ns, input logic [31:0] ne, input logic [63:0] tgt);
        logic [31:0] n;
        bit fnd;
        bit go;
        int nh;
        n = ns; fnd = 0; go = 1; nh = 0;
        while (go) begin
            push_words(n, MSG_WORDS);
            nh++;
            if (lw_func(mode, n) <= tgt) begin
                fnd = 1; fn_model = n; go = 0;
            end else if (n == ne) begin
                go = 0;
            end else begin
                n = n + 32'd1;
            end
        end
        exp_res_q.push_back('{fnd: fnd, fn: fn_model, cur: n, err: 1'b0});
        return nh;
    endfunction

    // Stand-in skein core: consumes the message, then emits OUT_WORDS digest words.
    int phase = 0;
    int reads = 0;
    int lat = 0;
    int wr_n = 0;
    logic [31:0] seen_n = 32'd0;
    initial begin
        src_read = 1'b0; dst_write = 1'b0; dout = '0;
        forever begin
            @(posedge clk); #1;
            src_read = 1'b0; dst_write = 1'b0; dout = {$urandom, $urandom};
            if (!reset_n || core_rst) begin
                phase = 0; reads = 0;
                src_read = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) begin dst_write = 1'b1; dout = '0; end
            end else begin
                case (phase)
                    0: if (!src_ready) begin
                        if (reads < max_reads && $urandom_range(0, 3) != 0) begin
                            src_read = 1'b1;
                            if (reads == NONCE_IDX) seen_n = din[31:0];
                            reads++;
                            if (reads == MSG_WORDS) begin
                                phase = 1; lat = $urandom_range(0, 3); wr_n = 0;
                            end
                        end else if ($urandom_range(0, 4) == 0) begin
                            dst_write = 1'b1; dout = '0;
                        end
                    end
                    1: if (lat > 0) lat--; else phase = 2;
                    2: if (mode != 3 && $urandom_range(0, 2) != 0) begin
                        dst_write = 1'b1;
                        dout = (wr_n == OUT_WORDS - 1) ? lw_func(mode, seen_n) : {$urandom, $urandom};
                        wr_n++;
                        if (wr_n == OUT_WORDS) phase = 3;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: checks every din handshake and every sweep result against the scoreboard.
    logic prev_core_rst = 1'b1;
    logic prev_src_ready = 1'b1;
    logic prev_error = 1'b0;
    logic prev_done = 1'b0;
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (src_read && !src_ready) begin
                    hs_cnt++;
                    if (exp_din_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL din_extra: unexpected handshake din=%h (cycle %0d)", din, cyc);
                    end else begin
                        chk("din_word", din, exp_din_q.pop_front());
                    end
                end
                if (prev_core_rst && !core_rst) crst_falls++;
                if (src_ready && !prev_src_ready) srdy_rise_cyc = cyc;
                if (error && !prev_error) err_rise_cyc = cyc;
                if (done && !prev_done) begin
                    if (exp_res_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL done_extra: unexpected done (cycle %0d)", cyc);
                    end else begin
                        r = exp_res_q.pop_front();
                        chk("res_found", found, r.fnd);
                        chk("res_found_nonce", found_nonce, r.fn);
                        chk("res_cur_nonce", cur_nonce, r.cur);
                        chk("res_error", error, r.err);
                        chk("res_busy", busy, 0);
                        chk("res_core_rst", core_rst, 1);
                        chk("res_src_ready", src_ready, 1);
                    end
                end
            end
            prev_core_rst = core_rst;
            prev_src_ready = src_ready;
            prev_error = error;
            prev_done = done;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic write_msg(input int k, input logic [63:0] v);
        cfg_we = 1'b1; cfg_addr = 4'(k); cfg_wdata = v;
        tick;
        cfg_we = 1'b0;
        msg_m[k] = v;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin tick; i++; end
        if (!done) begin
            checks++; failures++;
            $display("FAIL wait_done: done=%b after %0d cycles", done, budget);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_src_ready"}, src_ready, 1);
        chk({tag, "_dst_ready"}, dst_ready, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_found_nonce"}, found_nonce, 0);
        chk({tag, "_cur_nonce"}, cur_nonce, 0);
    endtask

    // Start a sweep, disturb it with an ignored start and a dropped cfg write, then wait for done.
    task automatic run_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [63:0] tgt, input int m);
        int nh;
        mode = m; hs_cnt = 0; crst_falls = 0;
        nh = predict(ns, ne, tgt);
        nonce_start = ns; nonce_end = ne; target = tgt; start = 1'b1;
        tick;
        start = 1'b1; nonce_start = $urandom; nonce_end = $urandom; target = {$urandom, $urandom};
        cfg_we = 1'b1; cfg_addr = 4'($urandom_range(0, MSG_WORDS - 1)); cfg_wdata = {$urandom, $urandom};
        tick;
        start = 1'b0; cfg_we = 1'b0;
        wait_done(nh * 80 + 100);
        tick;
        chk("hs_count", hs_cnt, nh * MSG_WORDS);
        chk("crst_pulses", crst_falls, nh);
        chk("din_leftover", exp_din_q.size(), 0);
        chk("res_leftover", exp_res_q.size(), 0);
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int len;
        int k;
        logic [31:0] ns;
        logic [63:0] tgt;

        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; abort = 1'b0;
        nonce_start = '0; nonce_end = '0; target = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick;

        // A: single nonce, always-hit target
        for (int w = 0; w < MSG_WORDS; w++) write_msg(w, 64'h1111_1111_1111_1111 * (w + 1));
        run_sweep(32'd5, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("A_handshakes", hs_cnt, 10);
        chk("A_done", done, 1);
        chk("A_found", found, 1);
        chk("A_found_nonce", found_nonce, 32'd5);

        // B: never-hit target over four nonces
        run_sweep(32'd0, 32'd3, 64'd0, 0);
        chk("B_crst_pulses", crst_falls, 4);
        chk("B_found", found, 0);
        chk("B_cur_nonce", cur_nonce, 32'd3);

        // C: exact-equality hit at nonce 2 stops the sweep
        run_sweep(32'd0, 32'd100, 64'h10, 1);
        chk("C_found_nonce", found_nonce, 32'd2);
        repeat (20) tick;
        chk("C_no_more_crst", crst_falls, 3);
        chk("C_idle_busy", busy, 0);

        // D: wrap through 0xFFFFFFFF
        run_sweep(32'hFFFF_FFFE, 32'd1, 64'd0, 0);
        chk("D_crst_pulses", crst_falls, 4);
        chk("D_cur_nonce", cur_nonce, 32'd1);

        // Random sweeps with random messages and near-miss targets
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < MSG_WORDS; w++) write_msg(w, {$urandom, $urandom});
            ns = $urandom;
            len = $urandom_range(0, 4);
            k = $urandom_range(0, len + 1);
            tgt = lw_func(2, ns + 32'(k));
            if ($urandom_range(0, 1) == 1) tgt = tgt - 64'd1;
            run_sweep(ns, ns + 32'(len), tgt, 2);
        end

        // Abort while din holds word 4; an earlier start during busy must not restart
        mode = 0; hs_cnt = 0; max_reads = 4;
        push_words(32'd0, 4);
        exp_res_q.push_back('{fnd: 1'b0, fn: fn_model, cur: 32'd0, err: 1'b0});
        nonce_start = 32'd0; nonce_end = 32'd10; target = 64'd0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1; nonce_start = 32'd50;
        tick;
        start = 1'b0;
        i = 0;
        while (hs_cnt < 4 && i < 200) begin tick; i++; end
        chk("abort_reached_word4", hs_cnt, 4);
        chk("abort_pre_src_ready", src_ready, 0);
        chk("abort_pre_din", din, msg_m[4]);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 1);
        chk("abort_src_ready", src_ready, 1);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_found", found, 0);
        chk("abort_cur_nonce", cur_nonce, 32'd0);
        tick; tick;
        max_reads = 99;
        chk("abort_din_leftover", exp_din_q.size(), 0);
        chk("abort_res_leftover", exp_res_q.size(), 0);

        // Drain timeout: core never writes
        mode = 3;
        push_words(32'd7, MSG_WORDS);
        exp_res_q.push_back('{fnd: 1'b0, fn: fn_model, cur: 32'd7, err: 1'b1});
        nonce_start = 32'd7; nonce_end = 32'd9; target = 64'd0; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done(300);
        tick;
        chk("timeout_error", error, 1);
        chk("timeout_cycles", err_rise_cyc - srdy_rise_cyc, TIMEOUT);
        chk("timeout_res_leftover", exp_res_q.size(), 0);
        run_sweep(32'd5, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        chk("restart_error_cleared", error, 0);
        chk("restart_found", found, 1);

        // Asynchronous reset in the middle of a sweep
        mode = 0;
        void'(predict(32'd0, 32'd50, 64'd0));
        nonce_start = 32'd0; nonce_end = 32'd50; target = 64'd0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (30) tick;
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_din_q.delete();
        exp_res_q.delete();
        tick; tick;
        reset_n = 1'b1;
        repeat (5) tick;
        chk("post_reset_done", done, 0);
        chk("post_reset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
